// File: rtl/fc1_ber_mon_if.sv
// Decoded PCS block stream plus BER/error status returned by fc1_ber_mon.
// The slave modport is the monitor's view; the master modport is the source/consumer view.
interface fc1_ber_mon_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic [63:0]          iPCS_DOUT;
  logic [1:0]           iPCS_DOUT_SH;
  logic                 iPCS_DOUT_EN;
  logic                 iPCS_DOUT_BLOCK_SYNC;
  logic                 iCNT_CLR;
  logic                 oHI_BER;
  logic                 oHI_BER_EV;
  logic [5:0]           oBER_CNT;
  logic                 oERR_BLK_EV;
  logic [ERR_CNT_W-1:0] oERR_BLK_CNT;

  modport slave (
    input  iPCS_DOUT, iPCS_DOUT_SH, iPCS_DOUT_EN, iPCS_DOUT_BLOCK_SYNC, iCNT_CLR,
    output oHI_BER, oHI_BER_EV, oBER_CNT, oERR_BLK_EV, oERR_BLK_CNT
  );

  modport master (
    output iPCS_DOUT, iPCS_DOUT_SH, iPCS_DOUT_EN, iPCS_DOUT_BLOCK_SYNC, iCNT_CLR,
    input  oHI_BER, oHI_BER_EV, oBER_CNT, oERR_BLK_EV, oERR_BLK_CNT
  );
endinterface

// File: rtl/fc1_ber_mon.sv
// Windowed invalid-sync-header BER monitor and errored-block counter for the
// FC1 64b/66b receive path; single RX clock domain.
module fc1_ber_mon #(
  parameter int unsigned WIN_CYC    = 26562,
  parameter int unsigned BER_THRESH = 16,
  parameter int unsigned ERR_CNT_W  = 16
) (
  input  logic          iRX_CLK,
  input  logic          iRX_RST_N,
  fc1_ber_mon_if.slave  bus
);

  localparam int unsigned          TimerW    = $clog2(WIN_CYC);
  localparam logic [TimerW-1:0]    TimerLast = TimerW'(WIN_CYC - 1);
  localparam logic [5:0]           Thresh    = 6'(BER_THRESH);
  localparam logic [ERR_CNT_W-1:0] ErrMax    = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {StInit, StTest, StHi} state_e;

  state_e                r_state, w_state_nxt;
  logic [TimerW-1:0]     r_timer, w_timer_nxt;
  logic [5:0]            r_ber_cnt, w_ber_cnt_nxt;
  logic [5:0]            r_ber_out, w_ber_out_nxt;
  logic                  r_hi_ev;
  logic                  r_err_ev;
  logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;

  logic       w_sync, w_blk_ok, w_bad_sh, w_type_ok, w_err_blk;
  logic [5:0] w_cnt_inc;
  logic       w_thresh, w_win_end;
  logic       w_unused;

  // Only the control type byte is inspected; the payload passes by untouched.
  assign w_unused  = ^bus.iPCS_DOUT[63:8];
  assign w_sync    = bus.iPCS_DOUT_BLOCK_SYNC;
  assign w_blk_ok  = bus.iPCS_DOUT_EN & w_sync;
  assign w_bad_sh  = w_blk_ok & (bus.iPCS_DOUT_SH == 2'b00 || bus.iPCS_DOUT_SH == 2'b11);
  assign w_err_blk = w_bad_sh | (w_blk_ok & (bus.iPCS_DOUT_SH == 2'b10) & ~w_type_ok);

  always_comb begin
    w_type_ok = 1'b0;
    case (bus.iPCS_DOUT[7:0])
      8'h1E, 8'h2D, 8'h33, 8'h4B, 8'h55, 8'h66, 8'h78, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: w_type_ok = 1'b1;
      default: w_type_ok = 1'b0;
    endcase
  end

  assign w_cnt_inc = (w_bad_sh && r_ber_cnt != 6'h3F) ? r_ber_cnt + 6'd1 : r_ber_cnt;
  assign w_thresh  = (w_cnt_inc >= Thresh);
  assign w_win_end = (r_timer == TimerLast);

  // State register
  always_ff @(posedge iRX_CLK or negedge iRX_RST_N) begin
    if (!iRX_RST_N) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and window datapath
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_ber_cnt_nxt = r_ber_cnt;
    w_ber_out_nxt = r_ber_out;
    if (!w_sync) begin
      // Lock loss discards the partial window but keeps the last reported count.
      w_state_nxt   = StInit;
      w_timer_nxt   = '0;
      w_ber_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        StInit: w_state_nxt = StTest;
        StTest, StHi: begin
          if (w_thresh) w_state_nxt = StHi;
          if (w_win_end) begin
            w_ber_out_nxt = w_cnt_inc;
            w_timer_nxt   = '0;
            w_ber_cnt_nxt = '0;
            w_state_nxt   = w_thresh ? StHi : StTest;
          end else begin
            w_timer_nxt   = r_timer + 1'b1;
            w_ber_cnt_nxt = w_cnt_inc;
          end
        end
        default: w_state_nxt = StInit;
      endcase
    end
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (bus.iCNT_CLR) begin
      w_err_cnt_nxt = ERR_CNT_W'(w_err_blk);
    end else if (w_err_blk && r_err_cnt != ErrMax) begin
      w_err_cnt_nxt = r_err_cnt + 1'b1;
    end
  end

  always_ff @(posedge iRX_CLK or negedge iRX_RST_N) begin
    if (!iRX_RST_N) begin
      r_timer   <= '0;
      r_ber_cnt <= '0;
      r_ber_out <= '0;
      r_hi_ev   <= 1'b0;
      r_err_ev  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_ber_cnt <= w_ber_cnt_nxt;
      r_ber_out <= w_ber_out_nxt;
      r_hi_ev   <= (w_state_nxt == StHi) && (r_state != StHi);
      r_err_ev  <= w_err_blk;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  // Outputs
  always_comb begin
    bus.oHI_BER      = (r_state == StHi);
    bus.oHI_BER_EV   = r_hi_ev;
    bus.oBER_CNT     = r_ber_out;
    bus.oERR_BLK_EV  = r_err_ev;
    bus.oERR_BLK_CNT = r_err_cnt;
  end

endmodule

// File: tb/tb_fc1_ber_mon.sv
// Directed bench for fc1_ber_mon: error-path vector table plus hand-written
// window sequences with WIN_CYC=100, BER_THRESH=16, ERR_CNT_W=4.
module tb_fc1_ber_mon;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc1_ber_mon_if #(.ERR_CNT_W(4)) bus ();

  fc1_ber_mon #(
    .WIN_CYC   (100),
    .BER_THRESH(16),
    .ERR_CNT_W (4)
  ) dut (
    .iRX_CLK  (clk),
    .iRX_RST_N(rst_n),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic       en;
    logic       sync;
    logic [1:0] sh;
    logic [7:0] typ;
    logic       clr;
    logic       exp_ev;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic en, input logic sync, input logic [1:0] sh,
                       input logic [7:0] typ, input logic clr);
    bus.iPCS_DOUT            = {56'h0, typ};
    bus.iPCS_DOUT_SH         = sh;
    bus.iPCS_DOUT_EN         = en;
    bus.iPCS_DOUT_BLOCK_SYNC = sync;
    bus.iCNT_CLR             = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " hi_ber"}, int'(bus.oHI_BER), 0);
    chk({tag, " hi_ber_ev"}, int'(bus.oHI_BER_EV), 0);
    chk({tag, " ber_cnt"}, int'(bus.oBER_CNT), 0);
    chk({tag, " err_ev"}, int'(bus.oERR_BLK_EV), 0);
    chk({tag, " err_cnt"}, int'(bus.oERR_BLK_CNT), 0);
  endtask

  // Assert reset, check outputs immediately, release, then lock so the next cycle is timer 0.
  task automatic reset_and_lock(input string tag);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b01, 8'h00, 1'b0);
    #1;
    chk_zero(tag);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b0);
    step();
  endtask

  initial begin
    int m;
    int ev_n;
    int hi_seen;
    int err_n;

    drive(1'b0, 1'b0, 2'b01, 8'h00, 1'b0);
    #1;
    chk_zero("reset");
    step();
    rst_n = 1'b1;

    // Error path table; expected values are post-edge outputs for each input row.
    vecs[0]  = '{1'b1, 1'b1, 2'b10, 8'h1E, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1};
    vecs[2]  = '{1'b1, 1'b1, 2'b10, 8'hFF, 1'b0, 1'b0, 1};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 8'h5A, 1'b0, 1'b1, 2};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b1, 3};
    vecs[5]  = '{1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 3};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 3};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 1};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1};
    vecs[11] = '{1'b1, 1'b1, 2'b10, 8'h87, 1'b0, 1'b0, 1};
    vecs[12] = '{1'b1, 1'b1, 2'b10, 8'h88, 1'b0, 1'b1, 2};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].en, vecs[i].sync, vecs[i].sh, vecs[i].typ, vecs[i].clr);
      step();
      chk($sformatf("vec%0d err_ev", i), int'(bus.oERR_BLK_EV), int'(vecs[i].exp_ev));
      chk($sformatf("vec%0d err_cnt", i), int'(bus.oERR_BLK_CNT), vecs[i].exp_cnt);
    end

    // Saturation at 15, then clear coincident with an errored block, then clear alone.
    drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b1);
    step();
    chk("sat clr", int'(bus.oERR_BLK_CNT), 0);
    m = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0);
      step();
      m = (m < 15) ? m + 1 : 15;
      chk($sformatf("sat cnt%0d", i), int'(bus.oERR_BLK_CNT), m);
    end
    drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b1);
    step();
    chk("clr+err cnt", int'(bus.oERR_BLK_CNT), 1);
    drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b1);
    step();
    chk("clr alone cnt", int'(bus.oERR_BLK_CNT), 0);

    // A: 15 bad SH spread over one window.
    reset_and_lock("rstA");
    hi_seen = 0;
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'b1, (t % 6 == 0 && t < 90) ? 2'b00 : 2'b01, 8'h00, 1'b0);
      step();
      if (bus.oHI_BER) hi_seen = 1;
      if (t == 98) chk("A ber_cnt before end", int'(bus.oBER_CNT), 0);
    end
    chk("A hi never", hi_seen, 0);
    chk("A ber_cnt", int'(bus.oBER_CNT), 15);

    // B: 16 bad SH in cycles 10..25, then a clean window.
    ev_n = 0;
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'b1, (t >= 10 && t <= 25) ? 2'b00 : 2'b01, 8'h00, 1'b0);
      step();
      ev_n += int'(bus.oHI_BER_EV);
      if (t == 24) chk("B hi before 16th", int'(bus.oHI_BER), 0);
      if (t == 25) begin
        chk("B hi after 16th", int'(bus.oHI_BER), 1);
        chk("B ev after 16th", int'(bus.oHI_BER_EV), 1);
      end
    end
    chk("B ev count", ev_n, 1);
    chk("B ber_cnt", int'(bus.oBER_CNT), 16);
    chk("B hi at end", int'(bus.oHI_BER), 1);
    ev_n = 0;
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'b1, 2'b01, 8'h00, 1'b0);
      step();
      ev_n += int'(bus.oHI_BER_EV);
      if (t == 98) chk("B2 hi before end", int'(bus.oHI_BER), 1);
    end
    chk("B2 hi cleared", int'(bus.oHI_BER), 0);
    chk("B2 ber_cnt", int'(bus.oBER_CNT), 0);
    chk("B2 ev count", ev_n, 0);

    // C: 15 bad SH, then the 16th on the window-end cycle; next window restarts at 0.
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'b1, (t < 15 || t == 99) ? 2'b00 : 2'b01, 8'h00, 1'b0);
      step();
      if (t == 98) chk("C hi before end", int'(bus.oHI_BER), 0);
    end
    chk("C hi at end", int'(bus.oHI_BER), 1);
    chk("C ev at end", int'(bus.oHI_BER_EV), 1);
    chk("C ber_cnt", int'(bus.oBER_CNT), 16);
    for (int t = 0; t < 100; t++) begin
      drive(1'b1, 1'b1, (t < 15) ? 2'b00 : 2'b01, 8'h00, 1'b0);
      step();
      if (t == 98) chk("C2 hi held", int'(bus.oHI_BER), 1);
    end
    chk("C2 ber_cnt restarted", int'(bus.oBER_CNT), 15);
    chk("C2 hi cleared", int'(bus.oHI_BER), 0);

    // D: enter HI, drop lock for one cycle, then a window of EN=0 invalid SH.
    for (int t = 0; t < 20; t++) begin
      drive(1'b1, 1'b1, (t < 16) ? 2'b00 : 2'b01, 8'h00, 1'b0);
      step();
      if (t == 15) chk("D hi entered", int'(bus.oHI_BER), 1);
    end
    drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
    step();
    chk("D hi after sync drop", int'(bus.oHI_BER), 0);
    chk("D ber_cnt held", int'(bus.oBER_CNT), 15);
    chk("D no err without sync", int'(bus.oERR_BLK_EV), 0);
    drive(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
    step();
    err_n = 0;
    hi_seen = 0;
    for (int t = 0; t < 100; t++) begin
      drive(1'b0, 1'b1, 2'b00, 8'h00, 1'b0);
      step();
      err_n += int'(bus.oERR_BLK_EV);
      if (bus.oHI_BER) hi_seen = 1;
      if (t == 98) chk("D ber_cnt before new end", int'(bus.oBER_CNT), 15);
    end
    chk("D ber_cnt en0 window", int'(bus.oBER_CNT), 0);
    chk("D err_ev en0", err_n, 0);
    chk("D hi en0", hi_seen, 0);

    // E: async reset mid-window while in HI.
    for (int t = 0; t < 16; t++) begin
      drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0);
      step();
    end
    chk("E hi before reset", int'(bus.oHI_BER), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("E async reset");
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fc1_ber_mon.md
Name: fc1_ber_mon

Overview:
- Receive-side BER monitor directly downstream of the FC1 64b/66b decoder, on the RX clock domain.
- Consumes the decoded PCS block stream (data, sync header, enable, block sync) and runs a windowed invalid-sync-header counter.
- Asserts a high-BER indication and counts errored control blocks.
- Feeds per-window BER status and saturating error counts to CSR and interval stats.

Parameters:
WIN_CYC, 26562, window length in iRX_CLK cycles (125 us at 212.5 MHz); legal range 16..65535
BER_THRESH, 16, invalid-sync-header count within one window that asserts high BER; legal range 1..63
ERR_CNT_W, 16, width of the saturating errored-block counter

Ports:
iRX_CLK  in  1  RX clock; all logic is in this single domain
iRX_RST_N  in  1  asynchronous active-low reset
iPCS_DOUT  in  64  decoded block; [7:0] is the control block type byte when SH=2'b10
iPCS_DOUT_SH  in  2  sync header; 2'b01 = data, 2'b10 = control, 2'b00 and 2'b11 = invalid
iPCS_DOUT_EN  in  1  block valid qualifier
iPCS_DOUT_BLOCK_SYNC  in  1  decoder block lock
iCNT_CLR  in  1  synchronous clear of oERR_BLK_CNT, one-cycle pulse
oHI_BER  out  1  high-BER status
oHI_BER_EV  out  1  one-cycle pulse on the 0->1 transition of oHI_BER
oBER_CNT  out  6  invalid-SH count in the last completed window, saturating at 63
oERR_BLK_EV  out  1  one-cycle pulse per errored block
oERR_BLK_CNT  out  ERR_CNT_W  saturating errored-block count

Behaviour:
- Reset: the following hold asynchronously while iRX_RST_N=0 and are released on the first iRX_CLK edge after deassertion.
  - All outputs are 0.
  - State is INIT; timer = 0; ber_cnt = 0.
- Invalid-SH event (bad_sh):
  - iPCS_DOUT_EN=1 && iPCS_DOUT_BLOCK_SYNC=1 && SH in {00,11}.
  - Cycles with EN=0 are ignored.
- Errored block (err_blk): EN=1 && BLOCK_SYNC=1 && either of:
  - bad_sh, or
  - SH=10 with type byte not in {1E,2D,33,4B,55,66,78,87,99,AA,B4,CC,D2,E1,FF}.
- State machine: INIT, TEST, HI.
  - INIT: timer = 0, ber_cnt = 0, oHI_BER = 0. Go to TEST the first cycle BLOCK_SYNC=1.
  - TEST: timer increments every cycle. ber_cnt increments on bad_sh and saturates at 63.
    - When ber_cnt+bad_sh reaches BER_THRESH, go to HI the next cycle, and oHI_BER=1 the same edge.
  - HI: counting continues as in TEST.
  - Window end (timer == WIN_CYC-1), in TEST or HI:
    - oBER_CNT <= ber_cnt + bad_sh of that cycle (saturated).
    - If the final count < BER_THRESH, go to TEST and set oHI_BER=0; otherwise stay in HI.
    - timer and ber_cnt restart at 0 the next cycle.
  - A bad_sh on the window-end cycle belongs to the ending window.
  - Threshold reached on the window-end cycle: oHI_BER=1 and the state stays/enters HI.
  - BLOCK_SYNC=0 in any state: go to INIT next cycle.
    - oHI_BER clears; oBER_CNT is held (not cleared).
    - The partial window is discarded.
- oHI_BER_EV: registered, asserted the cycle oHI_BER first reads 1.
- Error path, latency 1 cycle from input to outputs:
  - oERR_BLK_EV = registered err_blk.
  - oERR_BLK_CNT increments by 1 per err_blk and saturates at all-ones.
  - iCNT_CLR with a coincident err_blk: the count becomes 1 (clear, then count).
  - iCNT_CLR alone: the count becomes 0.
- Timer width: ceil(log2(WIN_CYC)). No wrap beyond WIN_CYC-1.
- BLOCK_SYNC deasserted mid-block: the block is ignored in the same cycle, i.e. it produces no bad_sh and no err_blk.

Test Plan:
- WIN_CYC=100, BER_THRESH=16. Sync=1, 15 bad SH spread over one window -> oHI_BER stays 0 and oBER_CNT=15 at window end.
- Same window settings, 16 bad SH in cycles 10..25 -> oHI_BER=1 on the edge after the 16th, oHI_BER_EV pulses once, and a following clean window clears oHI_BER at timer=99.
- 15 bad SH, then a 16th exactly at timer=99 -> oBER_CNT=16, oHI_BER=1, next window restarts with ber_cnt=0.
- Control blocks with type bytes 0x1E, 0x00, 0xFF, 0x5A and bad SH=11 -> three oERR_BLK_EV pulses and oERR_BLK_CNT=3.
- In HI state, drop BLOCK_SYNC for one cycle -> oHI_BER=0 next cycle, state INIT, oBER_CNT held. With EN=0 and invalid SH, no counts.
- ERR_CNT_W=4: 20 errored blocks -> count saturates at 15. Then iCNT_CLR coincident with an err_blk -> count=1. Async reset mid-window -> all outputs 0 immediately.
